// File: rtl/cc_stack_unit.sv
// cc_stack_unit
//   LC-3 condition-code unit with a shadow stack for interrupt save/restore.
//   {N,Z,P} is derived from the datapath bus as a signed WIDTH-bit value. A
//   DEPTH-entry stack saves the CC on interrupt entry and restores it on RTI.
//   The unit also evaluates the BR nzp mask against the registered CC.
//
// Parameters
//   WIDTH  bus width, two's complement operand, MSB is the sign
//   DEPTH  shadow stack entries (>= 1)
//   LVL_W  width of the stack level count
//
// Ports
//   i_Clk      system clock, all state changes on the rising edge
//   i_Rst_n    asynchronous active-low reset
//   LD_CC      load CC from BUS_OUT
//   BUS_OUT    datapath bus value
//   CC_PUSH    push the current CC onto the stack
//   CC_POP     pop the top of the stack into CC (wins over LD_CC)
//   ERR_CLR    clear the sticky STK_ERR
//   BR_EVAL    branch evaluation strobe (used only when CC_BR_REG_EN is defined)
//   BR_NZP     branch nzp mask {n,z,p}
//   N_OUT/Z_OUT/P_OUT  current condition code
//   BR_TAKEN   branch-taken result
//   STK_FULL, STK_EMPTY, STK_LEVEL  stack occupancy
//   STK_ERR    sticky overflow / underflow / push-pop conflict flag
//
// Build option
//   CC_BR_REG_EN  when defined, BR_TAKEN is registered on BR_EVAL; when
//                 undefined, BR_TAKEN is combinational and BR_EVAL is unused.

module cc_stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             LD_CC,
    input  logic [WIDTH-1:0] BUS_OUT,
    input  logic             CC_PUSH,
    input  logic             CC_POP,
    input  logic             ERR_CLR,
    input  logic             BR_EVAL,
    input  logic [2:0]       BR_NZP,
    output logic             N_OUT,
    output logic             Z_OUT,
    output logic             P_OUT,
    output logic             BR_TAKEN,
    output logic             STK_FULL,
    output logic             STK_EMPTY,
    output logic [LVL_W-1:0] STK_LEVEL,
    output logic             STK_ERR
);

    localparam logic [2:0]       CC_RESET = 3'b010;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [2:0]       cc_q;
    logic [2:0]       cc_d;
    logic [2:0]       bus_cc;
    logic [2:0]       top_cc;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             err_q;
    logic             err_d;
    logic [2:0]       stack_q [DEPTH];
    logic             is_full;
    logic             is_empty;
    logic             push_ok;
    logic             pop_ok;
    logic             stk_fault;
    logic             taken;

    assign is_full  = (level_q == LVL_FULL);
    assign is_empty = (level_q == '0);

    // A simultaneous push and pop is a conflict: neither is performed.
    assign push_ok   = CC_PUSH & ~CC_POP & ~is_full;
    assign pop_ok    = CC_POP & ~CC_PUSH & ~is_empty;
    assign stk_fault = (CC_PUSH & CC_POP) | (CC_PUSH & is_full) | (CC_POP & is_empty);

    // Flag derivation from the bus; the three cases are mutually exclusive,
    // so the result is always one-hot.
    always_comb begin
        bus_cc = 3'b001;
        if (BUS_OUT == '0) begin
            bus_cc = 3'b010;
        end else if (BUS_OUT[WIDTH-1]) begin
            bus_cc = 3'b100;
        end
    end

    // Top-of-stack read mux, entry level-1. Defaults to the reset CC so an
    // empty stack still yields a legal one-hot value (it is never selected).
    always_comb begin
        top_cc = CC_RESET;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LVL_W'(i + 1)) begin
                top_cc = stack_q[i];
            end
        end
    end

    // Any asserted CC_POP blocks LD_CC, including the empty and conflict
    // cases where the CC simply holds.
    always_comb begin
        cc_d    = cc_q;
        level_d = level_q;
        err_d   = err_q;

        if (CC_POP) begin
            if (pop_ok) begin
                cc_d = top_cc;
            end
        end else if (LD_CC) begin
            cc_d = bus_cc;
        end

        if (push_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_ok) begin
            level_d = level_q - LVL_W'(1);
        end

        if (stk_fault) begin
            err_d = 1'b1;
        end else if (ERR_CLR) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cc_q    <= CC_RESET;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cc_q    <= cc_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Stack storage needs no reset; entries are only read below the level.
    // The pushed value is the CC before any same-cycle load.
    always_ff @(posedge i_Clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok && (level_q == LVL_W'(i))) begin
                stack_q[i] <= cc_q;
            end
        end
    end

    assign taken = |(BR_NZP & cc_q);

`ifdef CC_BR_REG_EN
    logic br_q;

    // Samples the pre-load CC, so a coincident LD_CC does not affect it.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            br_q <= 1'b0;
        end else if (BR_EVAL) begin
            br_q <= taken;
        end
    end

    assign BR_TAKEN = br_q;
`else
    logic unused_br_eval;

    assign unused_br_eval = BR_EVAL;
    assign BR_TAKEN       = taken;
`endif

    assign N_OUT     = cc_q[2];
    assign Z_OUT     = cc_q[1];
    assign P_OUT     = cc_q[0];
    assign STK_FULL  = is_full;
    assign STK_EMPTY = is_empty;
    assign STK_LEVEL = level_q;
    assign STK_ERR   = err_q;

endmodule

// File: tb/tb_cc_stack_unit.sv
// tb_cc_stack_unit
//   Self-checking bench for cc_stack_unit (WIDTH=16, DEPTH=4). A directed
//   sequence walks the main scenarios, then randomized cycles run against a
//   queue-based reference model of the condition code and shadow stack.

module tb_cc_stack_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             i_Clk;
    logic             i_Rst_n;
    logic             LD_CC;
    logic [WIDTH-1:0] BUS_OUT;
    logic             CC_PUSH;
    logic             CC_POP;
    logic             ERR_CLR;
    logic             BR_EVAL;
    logic [2:0]       BR_NZP;
    logic             N_OUT;
    logic             Z_OUT;
    logic             P_OUT;
    logic             BR_TAKEN;
    logic             STK_FULL;
    logic             STK_EMPTY;
    logic [LVL_W-1:0] STK_LEVEL;
    logic             STK_ERR;

    int total_checks;
    int bad_checks;

    logic [2:0] m_cc;
    logic [2:0] m_stk [$];
    logic       m_err;
    logic       m_br;

    cc_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_Clk     (i_Clk),
        .i_Rst_n   (i_Rst_n),
        .LD_CC     (LD_CC),
        .BUS_OUT   (BUS_OUT),
        .CC_PUSH   (CC_PUSH),
        .CC_POP    (CC_POP),
        .ERR_CLR   (ERR_CLR),
        .BR_EVAL   (BR_EVAL),
        .BR_NZP    (BR_NZP),
        .N_OUT     (N_OUT),
        .Z_OUT     (Z_OUT),
        .P_OUT     (P_OUT),
        .BR_TAKEN  (BR_TAKEN),
        .STK_FULL  (STK_FULL),
        .STK_EMPTY (STK_EMPTY),
        .STK_LEVEL (STK_LEVEL),
        .STK_ERR   (STK_ERR)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        if (obs !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sign of the bus as an integer decides the flags.
    function automatic logic [2:0] refFlags(input logic [WIDTH-1:0] bus);
        int signed v;
        v = int'($signed(bus));
        if (v < 0) return 3'b100;
        if (v == 0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic modelReset();
        m_cc = 3'b010;
        m_stk.delete();
        m_err = 1'b0;
        m_br = 1'b0;
    endtask

    // One rising edge of the reference model, using the inputs driven for it.
    task automatic modelStep();
        logic [2:0] old_cc;
        logic       fault;
        old_cc = m_cc;
        fault = 1'b0;
        if (CC_PUSH && CC_POP) begin
            fault = 1'b1;
        end else if (CC_POP) begin
            if (m_stk.size() == 0) fault = 1'b1;
            else m_cc = m_stk.pop_back();
        end else begin
            if (CC_PUSH) begin
                if (m_stk.size() == DEPTH) fault = 1'b1;
                else m_stk.push_back(old_cc);
            end
            if (LD_CC) m_cc = refFlags(BUS_OUT);
        end
        if (fault) m_err = 1'b1;
        else if (ERR_CLR) m_err = 1'b0;
        if (BR_EVAL) m_br = |(BR_NZP & old_cc);
    endtask

    task automatic checkAll();
        logic exp_br;
`ifdef CC_BR_REG_EN
        exp_br = m_br;
`else
        exp_br = |(BR_NZP & m_cc);
`endif
        checkOutput("cc", {29'b0, N_OUT, Z_OUT, P_OUT}, {29'b0, m_cc});
        checkOutput("level", 32'(STK_LEVEL), 32'(m_stk.size()));
        checkOutput("full", 32'(STK_FULL), 32'(m_stk.size() == DEPTH));
        checkOutput("empty", 32'(STK_EMPTY), 32'(m_stk.size() == 0));
        checkOutput("err", 32'(STK_ERR), 32'(m_err));
        checkOutput("br", 32'(BR_TAKEN), 32'(exp_br));
    endtask

    task automatic applyStimulus(input logic ld, input logic [WIDTH-1:0] bus,
                                 input logic push, input logic pop, input logic clr,
                                 input logic eval, input logic [2:0] nzp);
        @(negedge i_Clk);
        LD_CC   = ld;
        BUS_OUT = bus;
        CC_PUSH = push;
        CC_POP  = pop;
        ERR_CLR = clr;
        BR_EVAL = eval;
        BR_NZP  = nzp;
        @(posedge i_Clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic clearInputs();
        LD_CC   = 1'b0;
        BUS_OUT = '0;
        CC_PUSH = 1'b0;
        CC_POP  = 1'b0;
        ERR_CLR = 1'b0;
        BR_EVAL = 1'b0;
        BR_NZP  = 3'b000;
    endtask

    // Asserts reset between edges so the asynchronous path is observed.
    task automatic pulseReset();
        @(negedge i_Clk);
        #2;
        clearInputs();
        i_Rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_cc", {29'b0, N_OUT, Z_OUT, P_OUT}, 32'h2);
        checkOutput("rst_level", 32'(STK_LEVEL), 32'h0);
        checkAll();
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] rbus;
        int sel;
        total_checks = 0;
        bad_checks = 0;
        clearInputs();
        i_Rst_n = 1'b0;
        modelReset();
        #12;
        checkAll();
        @(negedge i_Clk);
        i_Rst_n = 1'b1;

        // Flag derivation and hold
        applyStimulus(1, 16'h8000, 0, 0, 0, 0, 3'b000);
        checkOutput("ld_8000", {29'b0, N_OUT, Z_OUT, P_OUT}, 32'h4);
        applyStimulus(1, 16'h0000, 0, 0, 0, 0, 3'b000);
        checkOutput("ld_0000", {29'b0, N_OUT, Z_OUT, P_OUT}, 32'h2);
        applyStimulus(1, 16'h7FFF, 0, 0, 0, 0, 3'b000);
        checkOutput("ld_7fff", {29'b0, N_OUT, Z_OUT, P_OUT}, 32'h1);
        applyStimulus(0, 16'h0005, 0, 0, 0, 0, 3'b000);
        checkOutput("hold", {29'b0, N_OUT, Z_OUT, P_OUT}, 32'h1);

        // Save / restore
        applyStimulus(1, 16'hFFFF, 0, 0, 0, 0, 3'b000);
        applyStimulus(0, 16'h0000, 1, 0, 0, 0, 3'b000);
        checkOutput("push_level", 32'(STK_LEVEL), 32'h1);
        applyStimulus(1, 16'h0001, 0, 0, 0, 0, 3'b000);
        applyStimulus(0, 16'h0000, 0, 1, 0, 0, 3'b000);
        checkOutput("pop_cc", {29'b0, N_OUT, Z_OUT, P_OUT}, 32'h4);
        checkOutput("pop_empty", 32'(STK_EMPTY), 32'h1);

        // Overflow and error clear
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 16'h0000, 1, 0, 0, 0, 3'b000);
        checkOutput("full_flag", 32'(STK_FULL), 32'h1);
        applyStimulus(0, 16'h0000, 1, 0, 0, 0, 3'b000);
        checkOutput("ovf_err", 32'(STK_ERR), 32'h1);
        checkOutput("ovf_level", 32'(STK_LEVEL), 32'h4);
        applyStimulus(0, 16'h0000, 0, 0, 1, 0, 3'b000);
        checkOutput("err_clr", 32'(STK_ERR), 32'h0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 16'h0000, 0, 1, 0, 0, 3'b000);

        // Underflow with LD_CC, then push/pop conflict
        applyStimulus(1, 16'h0000, 0, 0, 0, 0, 3'b000);
        applyStimulus(1, 16'h0003, 0, 1, 0, 0, 3'b000);
        checkOutput("unf_cc", {29'b0, N_OUT, Z_OUT, P_OUT}, 32'h2);
        checkOutput("unf_err", 32'(STK_ERR), 32'h1);
        applyStimulus(0, 16'h0000, 0, 0, 1, 0, 3'b000);
        applyStimulus(1, 16'h8000, 1, 1, 0, 0, 3'b000);
        checkOutput("conf_level", 32'(STK_LEVEL), 32'h0);
        checkOutput("conf_err", 32'(STK_ERR), 32'h1);
        applyStimulus(0, 16'h0000, 0, 0, 1, 0, 3'b000);

        // Branch evaluation with CC=010
        applyStimulus(0, 16'h0000, 0, 0, 0, 1, 3'b010);
        checkOutput("br_010", 32'(BR_TAKEN), 32'h1);
        applyStimulus(0, 16'h0000, 0, 0, 0, 1, 3'b101);
        checkOutput("br_101", 32'(BR_TAKEN), 32'h0);
        applyStimulus(0, 16'h0000, 0, 0, 0, 1, 3'b000);
        checkOutput("br_000", 32'(BR_TAKEN), 32'h0);
        applyStimulus(0, 16'h0000, 0, 0, 0, 1, 3'b111);
        checkOutput("br_111", 32'(BR_TAKEN), 32'h1);

        // Push with same-cycle load keeps the old CC on the stack
        applyStimulus(1, 16'h7FFF, 0, 0, 0, 0, 3'b000);
        applyStimulus(1, 16'h0000, 1, 0, 0, 0, 3'b000);
        applyStimulus(0, 16'h0000, 0, 1, 0, 0, 3'b000);
        checkOutput("push_ld_pop", {29'b0, N_OUT, Z_OUT, P_OUT}, 32'h1);

        // Reset in the middle of a sequence
        applyStimulus(0, 16'h0000, 1, 0, 0, 0, 3'b000);
        applyStimulus(0, 16'h0000, 1, 0, 0, 0, 3'b000);
        pulseReset();

        // Randomized cycles against the reference model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulseReset();
            end else begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: rbus = 16'h0000;
                    1: rbus = 16'h8000;
                    2: rbus = 16'h7FFF;
                    3: rbus = 16'hFFFF;
                    default: rbus = WIDTH'($urandom);
                endcase
                applyStimulus($urandom_range(0, 1), rbus,
                              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                              $urandom_range(0, 3) == 0, $urandom_range(0, 1),
                              3'($urandom_range(0, 7)));
            end
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
